// File: rtl/rr_mux_stream.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_stream
// Description : WAYS-input, WIDTH-bit valid/ready stream mux with round-robin
//               arbitration into a one-entry registered output stage.
//               Optional packet locking compiled in with RR_MUX_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_stream #(
    parameter int WIDTH = 8,
    parameter int WAYS  = 8,
    localparam int SEL_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [WAYS-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] r_last_grant;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    logic             w_load_en;
    logic [WAYS-1:0]  w_elig;
    logic             w_any;
    logic [SEL_W-1:0] w_grant;
    logic             w_load;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_load    = w_load_en && w_any;

    // Scan last_grant+1 .. last_grant+WAYS modulo WAYS; first eligible wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = '0;
        for (int k = 1; k <= WAYS; k++) begin
            idx = SEL_W'((int'(r_last_grant) + k) % WAYS);
            if (!w_any && w_elig[idx]) begin
                w_any   = 1'b1;
                w_grant = idx;
            end
        end
    end

    // Gated by rst so producers never see an acceptance that reset will discard.
    assign in_ready = (w_load && !rst) ? (WAYS'(1) << w_grant) : '0;

`ifdef RR_MUX_LOCK_EN
    localparam logic [0:0] c_ST_ARB    = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] w_lock_ch_nxt;
    logic             r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_ARB;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_ch_nxt = r_lock_ch;
        if (w_load) begin
            case (r_state)
                c_ST_ARB: begin
                    if (!in_last[w_grant]) begin
                        w_state_nxt   = c_ST_LOCKED;
                        w_lock_ch_nxt = w_grant;
                    end
                end
                c_ST_LOCKED: begin
                    if (in_last[w_grant]) begin
                        w_state_nxt = c_ST_ARB;
                    end
                end
                default: w_state_nxt = c_ST_ARB;
            endcase
        end
    end

    // While locked only the owning channel may compete.
    always_comb begin
        w_elig = in_valid;
        if (r_state == c_ST_LOCKED) begin
            w_elig = in_valid & (WAYS'(1) << r_lock_ch);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_out_last <= in_last[w_grant];
        end
    end

    assign out_last = r_out_last;
`else
    assign w_elig = in_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_last_grant <= SEL_W'(WAYS - 1);
        end else if (w_load_en) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data   <= in_data[int'(w_grant)*WIDTH +: WIDTH];
                r_out_sel    <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
